spi_reg_ctrl: RTL

//  Transaction controller behind the SPI byte shifter (spi_slave). Parses the command byte, then runs

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_reg_ctrl_if.sv | 38 +++
 rtl/d_ff_wide.sv | 22 ++
 rtl/spi_ss_sync.sv | 28 ++
 rtl/spi_reg_ctrl.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Holds the FSM state encoding and the STATUS byte builder.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_FETCH,
    RD_WAIT,
    RD_HOLD
  } spi_ctrl_state_t;

  localparam int         SPI_CMD_RD_BIT = 7;
  localparam logic [3:0] SPI_REG_ID     = 4'h5;
  localparam int         SPI_MAX_RD_LAT = 4;

  function automatic logic [7:0] spi_status(input logic ovr);
    return {ovr, 3'b000, SPI_REG_ID};
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-shifter side and local register bus of the SPI controller.
// master = controller, slave = shifter plus register file.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);

  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata;

  modport master (
    input  byte_done,
    input  rx_byte,
    input  reg_rdata,
    output tx_byte,
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd
  );

  modport slave (
    output byte_done,
    output rx_byte,
    output reg_rdata,
    input  tx_byte,
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd
  );

endinterface

// File: rtl/d_ff_wide.sv
// Generic enabled register bank with asynchronous active-low reset.
// RST_VAL selects the per-bit reset value.
module d_ff_wide #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/spi_ss_sync.sv
// Two-flop synchroniser for the raw chip select plus edge pulses.
// Reset to 0 so a select held low across reset never looks like a fall.
module spi_ss_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ss,
  output logic rise,
  output logic fall
);

  logic [2:0] q;

  d_ff_wide #(
    .WIDTH  (3),
    .RST_VAL(3'b000)
  ) u_ff (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  ({q[1:0], ss}),
    .q  (q)
  );

  assign rise = q[1] & ~q[2];
  assign fall = ~q[1] & q[2];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: command parse, burst writes/reads
// on the local register bus with address auto-increment.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic ss,
  input  logic err_clr,
  output logic busy,
  output logic ovr_err,
  spi_reg_ctrl_if.master bus
);

  localparam int LAT_W = $clog2(SPI_MAX_RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(RD_LAT);

  spi_ctrl_state_t   state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ovr_q, ovr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ss_rise, ss_fall;
  logic              rd_phase;

  spi_ss_sync u_ss_sync (
    .clk (clk),
    .rst (rst),
    .en  (ena),
    .ss  (ss),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  always_comb begin
    state_d = state;
    addr_d  = addr;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    lat_d   = lat_q;
    ovr_d   = ovr_q;
    if (err_clr) begin
      ovr_d = 1'b0;
    end
    if (wr_q) begin
      addr_d = addr + 1'b1;
    end
    // Chip-select release aborts and swallows a same-cycle byte.
    if (ss_rise) begin
      state_d = IDLE;
    end else if (ss_fall) begin
      state_d = CMD;
    end else begin
      unique case (state)
        IDLE: begin
        end
        CMD: begin
          if (bus.byte_done) begin
            addr_d  = bus.rx_byte[ADDR_W-1:0];
            state_d = bus.rx_byte[SPI_CMD_RD_BIT]
                      ? RD_FETCH : WR;
          end
        end
        WR: begin
          if (bus.byte_done) begin
            wr_d    = 1'b1;
            wdata_d = bus.rx_byte;
          end
        end
        RD_FETCH: begin
          if (bus.byte_done) begin
            ovr_d = 1'b1;
          end
          lat_d   = LAT_W'(1);
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.byte_done) begin
            ovr_d = 1'b1;
          end
          if (lat_q == LAT) begin
            tx_d    = bus.reg_rdata;
            addr_d  = addr + 1'b1;
            state_d = RD_HOLD;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        RD_HOLD: begin
          if (bus.byte_done) begin
            state_d = RD_FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      tx_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      lat_q   <= '0;
    end else if (ena) begin
      state   <= state_d;
      addr    <= addr_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ovr_q   <= ovr_d;
      lat_q   <= lat_d;
    end else begin
      wr_q <= 1'b0;
    end
  end

  assign rd_phase = (state == RD_FETCH) |
                    (state == RD_WAIT)  |
                    (state == RD_HOLD);

  assign bus.tx_byte   = rd_phase ? tx_q : spi_status(ovr_q);
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr    = wr_q & ena;
  assign bus.reg_rd    = ena & (state == RD_FETCH);
  assign busy          = (state != IDLE);
  assign ovr_err       = ovr_q;

endmodule
